// File: rtl/unsadd_nch.sv
// N-input non-scaled unary adder: tracks the running sum of the input stream values
// and emits at most one output 1 per cycle so the output density follows the clamped sum.
module unsadd_nch #(
  parameter int NIN      = 4,
  parameter int WIN_LOG2 = 8,
  parameter int BIPOLAR  = 1
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iEn,
  input  logic [NIN-1:0]      iA,
  output logic                oC,
  output logic                oWinDone,
  output logic [WIN_LOG2:0]   oSum
);

  localparam int CW  = $clog2(NIN + 1);
  localparam int TW  = WIN_LOG2 + CW + 2;
  localparam int OFF = (BIPOLAR != 0) ? NIN - 1 : 0;
  localparam logic signed [TW-1:0] OFF_T = TW'(OFF);

  logic [CW-1:0]          ones;
  logic signed [TW-1:0]   tgt, tgt_n, acc2;
  logic [WIN_LOG2:0]      out_acc, acc_n;
  logic [WIN_LOG2-1:0]    win_cnt;
  logic                   emit, last;

  always_comb begin
    ones = '0;
    for (int i = 0; i < NIN; i++) ones = ones + CW'(iA[i]);
  end

  // Target and output count are both kept in doubled units so the bipolar
  // offset (NIN-1) never needs a fractional half step.
  assign tgt_n = tgt + $signed({{(TW-CW-1){1'b0}}, ones, 1'b0}) - OFF_T;
  assign acc2  = $signed({{(TW-WIN_LOG2-2){1'b0}}, out_acc, 1'b0});
  assign emit  = !tgt_n[TW-1] && (tgt_n != '0) && (tgt_n > acc2);
  assign acc_n = out_acc + {{WIN_LOG2{1'b0}}, emit};
  assign last  = &win_cnt;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      tgt      <= '0;
      out_acc  <= '0;
      win_cnt  <= '0;
      oC       <= 1'b0;
      oWinDone <= 1'b0;
      oSum     <= '0;
    end else if (iEn) begin
      oC       <= emit;
      oWinDone <= last;
      win_cnt  <= win_cnt + 1'b1;
      if (last) begin
        oSum    <= acc_n;
        tgt     <= '0;
        out_acc <= '0;
      end else begin
        tgt     <= tgt_n;
        out_acc <= acc_n;
      end
    end else begin
      oC       <= 1'b0;
      oWinDone <= 1'b0;
    end
  end

endmodule
